wur_seq_ctrl: RTL



---
 rtl/wur_pkg.sv | 18 +
 rtl/wur_seq_ctrl_if.sv | 30 +++
 rtl/wur_edge_sync.sv | 22 ++
 rtl/wur_seq_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/wur_pkg.sv
// Shared state encoding and default timing for the wake-up receiver sequencer.
// Defaults target a 100 MHz clock, 1 Mb/s frames of 1000 bits with a 432-bit preamble.
package wur_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } wur_state_t;

    localparam int DEF_CLK_DIV       = 100;
    localparam int DEF_SYNC_TIMEOUT  = 20000;
    localparam int DEF_NUM_BITS      = 1000;
    localparam int DEF_PREAMBLE_BITS = 432;
    localparam int DEF_CNT_W         = 20;

endpackage

// File: rtl/wur_seq_ctrl_if.sv
// Pin-side inputs and bit-timing/status outputs of the sequencer, bundled as one port.
// The master side drives the raw pins and enable; the slave side is the controller.
interface wur_seq_ctrl_if #(
    parameter int CNT_W = wur_pkg::DEF_CNT_W
);
    logic             enable;
    logic             wake_up;
    logic             comp_out;
    logic [1:0]       state;
    logic             data_clk_enb;
    logic             data_clk;
    logic             bit_tick;
    logic [CNT_W-1:0] bit_idx;
    logic             in_payload;
    logic             frame_done;
    logic             timeout_err;
    logic             aborted;

    modport master (
        output enable, wake_up, comp_out,
        input  state, data_clk_enb, data_clk, bit_tick, bit_idx,
        input  in_payload, frame_done, timeout_err, aborted
    );

    modport slave (
        input  enable, wake_up, comp_out,
        output state, data_clk_enb, data_clk, bit_tick, bit_idx,
        output in_payload, frame_done, timeout_err, aborted
    );
endinterface

// File: rtl/wur_edge_sync.sv
// Three-flop synchronizer with rising-edge detect for an asynchronous pin.
// A pin rising before edge k is flagged combinationally in the cycle after edge k+1.
module wur_edge_sync (
    input  logic clki,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_rise
);

    logic [2:0] r_sr;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= 3'b000;
        end else begin
            r_sr <= {r_sr[1:0], i_pin};
        end
    end

    assign o_rise = (r_sr[2:1] == 2'b01);

endmodule

// File: rtl/wur_seq_ctrl.sv
// Frame sequencer: arm on wake-up, wait for comparator sync, run fixed bit timing.
// State changes two clocks after a pin edge; no backpressure, enable low aborts to IDLE.
module wur_seq_ctrl
    import wur_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int SYNC_TIMEOUT  = DEF_SYNC_TIMEOUT,
    parameter int NUM_BITS      = DEF_NUM_BITS,
    parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic           clki,
    input  logic           rst_n,
    wur_seq_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TMO_LAST  = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_HALF      = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] C_HALF_M1   = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] C_BITS_LAST = CNT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] C_PREAMBLE  = CNT_W'(PREAMBLE_BITS);

    wur_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt;
    logic [CNT_W-1:0] r_phase, w_phase_nxt;
    logic [CNT_W-1:0] r_bit_idx, w_bit_idx_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_abort, w_abort_nxt;
    logic             w_wake_rise;
    logic             w_comp_rise;
    logic             w_in_data;

    wur_edge_sync u_wake_sync (
        .clki   (clki),
        .rst_n  (rst_n),
        .i_pin  (bus.wake_up),
        .o_rise (w_wake_rise)
    );

    wur_edge_sync u_comp_sync (
        .clki   (clki),
        .rst_n  (rst_n),
        .i_pin  (bus.comp_out),
        .o_rise (w_comp_rise)
    );

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_phase   <= '0;
            r_bit_idx <= '0;
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_phase   <= w_phase_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_timeout <= w_timeout_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_phase_nxt   = r_phase;
        w_bit_idx_nxt = r_bit_idx;
        w_timeout_nxt = 1'b0;
        w_abort_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable && w_wake_rise) begin
                    w_state_nxt = ST_ARMED;
                    w_timer_nxt = '0;
                end
            end
            ST_ARMED: begin
                // Sync is tested before expiry so a same-cycle edge still starts the frame.
                if (!bus.enable) begin
                    w_state_nxt = ST_IDLE;
                    w_abort_nxt = 1'b1;
                    w_timer_nxt = '0;
                end else if (w_comp_rise) begin
                    w_state_nxt   = ST_DATA;
                    w_timer_nxt   = '0;
                    w_phase_nxt   = '0;
                    w_bit_idx_nxt = '0;
                end else if (r_timer == C_TMO_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = 1'b1;
                    w_timer_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + C_ONE;
                end
            end
            ST_DATA: begin
                if (!bus.enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_abort_nxt   = 1'b1;
                    w_phase_nxt   = '0;
                    w_bit_idx_nxt = '0;
                end else if (r_phase == C_DIV_LAST) begin
                    w_phase_nxt = '0;
                    if (r_bit_idx == C_BITS_LAST) begin
                        w_state_nxt   = ST_DONE;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + C_ONE;
                    end
                end else begin
                    w_phase_nxt = r_phase + C_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_in_data = (r_state == ST_DATA);

    assign bus.state        = r_state;
    assign bus.data_clk_enb = w_in_data;
    assign bus.data_clk     = w_in_data && (r_phase >= C_HALF);
    assign bus.bit_tick     = w_in_data && (r_phase == C_HALF_M1);
    assign bus.bit_idx      = r_bit_idx;
    assign bus.in_payload   = w_in_data && (r_bit_idx >= C_PREAMBLE);
    assign bus.frame_done   = (r_state == ST_DONE);
    assign bus.timeout_err  = r_timeout;
    assign bus.aborted      = r_abort;

endmodule
